// File: rtl/i2c_wb_sequencer.sv
// Wishbone master that runs one complete I2C transaction per command through the
// I2C controller's register slave: START, busy/ack polling, data bytes, STOP.
module i2c_wb_sequencer #(
   parameter int         LEN_W    = 8,
   parameter int         POLL_MAX = 1024,
   parameter logic [7:0] A_START  = 8'd0,
   parameter logic [7:0] A_WRITE  = 8'd1,
   parameter logic [7:0] A_STOP   = 8'd2,
   parameter logic [7:0] A_ACK    = 8'd3,
   parameter logic [7:0] A_RD_RDY = 8'd4,
   parameter logic [7:0] A_BUSY   = 8'd5,
   parameter logic [7:0] A_READ   = 8'd6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_rw,
   input  logic [6:0]       cmd_slave,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [7:0]       wr_data,
   output logic             wr_pop,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   output logic             done,
   output logic [1:0]       status,
   output logic             o_wb_cyc,
   output logic             o_wb_stb,
   output logic             o_wb_we,
   output logic [7:0]       o_wb_addr,
   output logic [7:0]       o_wb_data,
   input  logic             i_wb_ack,
   input  logic [7:0]       i_wb_data
);

   localparam int             PW        = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX);
   localparam logic [PW-1:0]  POLL_LAST = PW'(POLL_MAX - 1);
   localparam logic [1:0]     ST_OK      = 2'b00;
   localparam logic [1:0]     ST_NACK    = 2'b01;
   localparam logic [1:0]     ST_TIMEOUT = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_WAIT, S_ACK, S_WBYTE, S_RRDY, S_RBYTE, S_STOP, S_DONE
   } state_t;

   state_t           state;
   logic             rw_q;
   logic [6:0]       slave_q;
   logic [LEN_W-1:0] count;
   logic [PW-1:0]    polls;

   logic             req_en;
   logic             req_we;
   logic [7:0]       req_addr;
   logic [7:0]       req_data;
   logic             ack_seen;

   // Each access-issuing state owns exactly one register access description.
   always_comb begin
      req_en   = 1'b1;
      req_we   = 1'b0;
      req_addr = 8'd0;
      req_data = 8'd0;
      case (state)
         S_START: begin req_we = 1'b1; req_addr = A_START; req_data = {slave_q, rw_q}; end
         S_WAIT:  req_addr = A_BUSY;
         S_ACK:   req_addr = A_ACK;
         S_WBYTE: begin req_we = 1'b1; req_addr = A_WRITE; req_data = wr_data; end
         S_RRDY:  req_addr = A_RD_RDY;
         S_RBYTE: req_addr = A_READ;
         S_STOP:  begin req_we = 1'b1; req_addr = A_STOP; req_data = 8'd1; end
         default: req_en = 1'b0;
      endcase
   end

   assign ack_seen = o_wb_cyc && i_wb_ack;

   // Accesses are raised only while the bus is idle and dropped on ack, which
   // guarantees at least one idle cycle between consecutive accesses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cmd_ready <= 1'b1;
         rw_q      <= 1'b0;
         slave_q   <= 7'd0;
         count     <= '0;
         polls     <= '0;
         wr_pop    <= 1'b0;
         rd_data   <= 8'd0;
         rd_valid  <= 1'b0;
         done      <= 1'b0;
         status    <= ST_OK;
         o_wb_cyc  <= 1'b0;
         o_wb_stb  <= 1'b0;
         o_wb_we   <= 1'b0;
         o_wb_addr <= 8'd0;
         o_wb_data <= 8'd0;
      end else begin
         wr_pop   <= 1'b0;
         rd_valid <= 1'b0;
         done     <= 1'b0;
         if (req_en && !o_wb_cyc) begin
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            o_wb_we   <= req_we;
            o_wb_addr <= req_addr;
            o_wb_data <= req_data;
         end
         if (ack_seen) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
         end
         case (state)
            S_IDLE: if (cmd_valid && cmd_ready) begin
               rw_q      <= cmd_rw;
               slave_q   <= cmd_slave;
               count     <= cmd_len;
               status    <= ST_OK;
               cmd_ready <= 1'b0;
               state     <= S_START;
            end
            S_START: if (ack_seen) begin
               polls <= '0;
               state <= S_WAIT;
            end
            S_WAIT: if (ack_seen) begin
               if (!i_wb_data[0]) state <= S_ACK;
               else if (polls == POLL_LAST) begin
                  status <= ST_TIMEOUT;
                  state  <= S_STOP;
               end else polls <= polls + PW'(1);
            end
            S_ACK: if (ack_seen) begin
               if (!i_wb_data[0]) begin
                  status <= ST_NACK;
                  state  <= S_STOP;
               end else if (count == '0) state <= S_STOP;
               else if (rw_q) begin
                  polls <= '0;
                  state <= S_RRDY;
               end else state <= S_WBYTE;
            end
            S_WBYTE: if (ack_seen) begin
               wr_pop <= 1'b1;
               count  <= count - LEN_W'(1);
               polls  <= '0;
               state  <= S_WAIT;
            end
            S_RRDY: if (ack_seen) begin
               if (i_wb_data[0]) state <= S_RBYTE;
               else if (polls == POLL_LAST) begin
                  status <= ST_TIMEOUT;
                  state  <= S_STOP;
               end else polls <= polls + PW'(1);
            end
            // Received data bytes are not ACK-checked; only the count decides.
            S_RBYTE: if (ack_seen) begin
               rd_valid <= 1'b1;
               rd_data  <= i_wb_data;
               count    <= count - LEN_W'(1);
               if (count == LEN_W'(1)) state <= S_STOP;
               else begin
                  polls <= '0;
                  state <= S_RRDY;
               end
            end
            S_STOP: if (ack_seen) begin
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               cmd_ready <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Randomized bench for i2c_wb_sequencer: a register-slave model plus a queue-based
// prediction of every Wishbone access, received byte, pop count and status.
module tb_i2c_wb_sequencer;

   localparam int         PM       = 16;
   localparam logic [7:0] A_START  = 8'd0;
   localparam logic [7:0] A_WRITE  = 8'd1;
   localparam logic [7:0] A_STOP   = 8'd2;
   localparam logic [7:0] A_ACK    = 8'd3;
   localparam logic [7:0] A_RD_RDY = 8'd4;
   localparam logic [7:0] A_BUSY   = 8'd5;
   localparam logic [7:0] A_READ   = 8'd6;

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } acc_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready, cmd_rw;
   logic [6:0] cmd_slave;
   logic [7:0] cmd_len;
   logic [7:0] wr_data, rd_data;
   logic       wr_pop, rd_valid, done;
   logic [1:0] status;
   logic       o_wb_cyc, o_wb_stb, o_wb_we;
   logic [7:0] o_wb_addr, o_wb_data;
   logic       i_wb_ack;
   logic [7:0] i_wb_data;

   // Expected behaviour of the current command
   acc_t       exp_acc[$];
   logic [7:0] exp_rd[$];
   logic [1:0] exp_status;
   acc_t       wlog[$];
   logic [7:0] rlog[$];
   logic [7:0] wpool[4096];
   logic [7:0] rpool[4096];

   // Slave configuration, written only by the stimulus process
   int busy_n, rdy_n, nack_at, ack_base, lat_mode;
   bit glitch_en;

   // Slave/checker state, written only by the compare process
   int         pop_cnt, rd_cnt, ack_total, busy_total, acc_total, done_cnt, cycle, done_cycle;
   int         lat, run;
   bit         served, glitch, prev_ack, prev_cyc;
   acc_t       prev_acc, cur, e;
   logic [7:0] last_addr, rdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign wr_data   = wpool[pop_cnt[11:0]];
   assign i_wb_ack  = (served && o_wb_cyc && o_wb_stb) || (glitch && !o_wb_cyc);
   assign i_wb_data = rdata;

   i2c_wb_sequencer #(.LEN_W(8), .POLL_MAX(PM)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_slave(cmd_slave), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
      .done(done), .status(status),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
      .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data)
   );

   task automatic checkOutput(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // Predict the full access sequence from the slave configuration.
   task automatic modelCommand(input bit rw, input logic [6:0] slave, input int len, output int pops);
      int  bytes = 0;
      int  acks  = 0;
      bit  fin   = 0;
      int  nb    = (busy_n + 1 < PM) ? busy_n + 1 : PM;
      int  nr    = (rdy_n + 1 < PM) ? rdy_n + 1 : PM;
      pops = 0;
      exp_status = 2'b00;
      exp_acc.delete();
      exp_rd.delete();
      exp_acc.push_back({1'b1, A_START, {slave, rw}});
      while (!fin) begin
         for (int i = 0; i < nb; i++) exp_acc.push_back({1'b0, A_BUSY, 8'd0});
         if (busy_n >= PM) begin
            exp_status = 2'b10;
            fin = 1;
         end else begin
            exp_acc.push_back({1'b0, A_ACK, 8'd0});
            if (acks == nack_at) begin
               exp_status = 2'b01;
               fin = 1;
            end else begin
               acks++;
               if (bytes >= len) fin = 1;
               else if (!rw) begin
                  exp_acc.push_back({1'b1, A_WRITE, wpool[(pop_cnt + bytes) % 4096]});
                  bytes++;
                  pops++;
               end else begin
                  while (bytes < len && !fin) begin
                     for (int i = 0; i < nr; i++) exp_acc.push_back({1'b0, A_RD_RDY, 8'd0});
                     if (rdy_n >= PM) begin
                        exp_status = 2'b10;
                        fin = 1;
                     end else begin
                        exp_acc.push_back({1'b0, A_READ, 8'd0});
                        exp_rd.push_back(rpool[(rd_cnt + bytes) % 4096]);
                        bytes++;
                     end
                  end
                  fin = 1;
               end
            end
         end
      end
      exp_acc.push_back({1'b1, A_STOP, 8'd1});
   endtask

   int acc_cycle;

   task automatic applyStimulus(input bit rw, input logic [6:0] slave, input int len,
                                input int bn, input int rn, input int na, input int lm,
                                input bit garbage);
      int n, d0, pop_base, exp_pops;
      busy_n   = bn;
      rdy_n    = rn;
      nack_at  = na;
      lat_mode = lm;
      ack_base = ack_total;
      pop_base = pop_cnt;
      modelCommand(rw, slave, len, exp_pops);
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         checkOutput("cmd_ready_wait", 0, 1);
         return;
      end
      d0        = done_cnt;
      cmd_valid = 1'b1;
      cmd_rw    = rw;
      cmd_slave = slave;
      cmd_len   = 8'(len);
      @(posedge clk);
      @(negedge clk);
      acc_cycle = cycle;
      checkOutput("cmd_ready_busy", int'(cmd_ready), 0);
      if (garbage) begin
         cmd_rw    = 1'($urandom);
         cmd_slave = 7'($urandom);
         cmd_len   = 8'($urandom);
         repeat (2) @(negedge clk);
      end
      cmd_valid = 1'b0;
      n = 0;
      while (done_cnt == d0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt == d0) checkOutput("done_wait", 0, 1);
      repeat (2) @(negedge clk);
      checkOutput("done_pulses", done_cnt - d0, 1);
      checkOutput("accesses_left", exp_acc.size(), 0);
      checkOutput("rd_bytes_left", exp_rd.size(), 0);
      checkOutput("wr_pops", pop_cnt - pop_base, exp_pops);
      checkOutput("cmd_ready_idle", int'(cmd_ready), 1);
      checkOutput("status_held", int'(status), int'(exp_status));
   endtask

   // Register-slave model and the single compare process, both away from posedge.
   always @(negedge clk) begin
      cycle++;
      if (!rst_n) begin
         served    = 0;
         glitch    = 0;
         prev_ack  = 0;
         prev_cyc  = 0;
         lat       = 0;
         last_addr = 8'hFF;
      end else begin
         cur = {o_wb_we, o_wb_addr, o_wb_data};
         if (prev_ack) checkOutput("cyc_gap", int'(o_wb_cyc), 0);
         checkOutput("stb_eq_cyc", int'(o_wb_stb), int'(o_wb_cyc));
         if (prev_cyc && o_wb_cyc && !prev_ack) checkOutput("wb_stable", int'(cur), int'(prev_acc));
         prev_cyc = o_wb_cyc;
         prev_acc = cur;
         if (!o_wb_cyc) begin
            served = 0;
            lat    = (lat_mode == 0) ? 0 : (lat_mode == 1) ? int'($urandom_range(0, 2)) : 5;
            glitch = glitch_en && ($urandom_range(0, 3) == 0);
         end else begin
            glitch = 0;
            if (!served) begin
               if (lat > 0) lat--;
               else begin
                  served = 1;
                  acc_total++;
                  if (exp_acc.size() == 0) checkOutput("unexpected_access", int'(cur), -1);
                  else begin
                     e = exp_acc.pop_front();
                     if (e.we) checkOutput("access_wr", int'(cur), int'(e));
                     else checkOutput("access_rd", int'({cur.we, cur.addr}), int'({e.we, e.addr}));
                  end
                  if (o_wb_we) begin
                     wlog.push_back(cur);
                     rdata = 8'($urandom);
                  end else begin
                     case (o_wb_addr)
                        A_BUSY: begin
                           if (last_addr != A_BUSY) run = 0;
                           rdata = {7'($urandom), 1'(run < busy_n)};
                           run++;
                           busy_total++;
                        end
                        A_RD_RDY: begin
                           if (last_addr != A_RD_RDY) run = 0;
                           rdata = {7'($urandom), 1'(run >= rdy_n)};
                           run++;
                        end
                        A_ACK: begin
                           rdata = {7'($urandom), 1'((ack_total - ack_base) != nack_at)};
                           ack_total++;
                        end
                        A_READ: begin
                           rdata = rpool[rd_cnt[11:0]];
                           rd_cnt++;
                        end
                        default: rdata = 8'($urandom);
                     endcase
                  end
                  last_addr = o_wb_addr;
               end
            end
         end
         prev_ack = served && o_wb_cyc;
         if (wr_pop) pop_cnt++;
         if (rd_valid) begin
            rlog.push_back(rd_data);
            if (exp_rd.size() == 0) checkOutput("rd_unexpected", int'(rd_data), -1);
            else checkOutput("rd_data", int'(rd_data), int'(exp_rd.pop_front()));
         end
         if (done) begin
            done_cnt++;
            done_cycle = cycle;
            checkOutput("status_at_done", int'(status), int'(exp_status));
            checkOutput("accesses_at_done", exp_acc.size(), 0);
         end
      end
   end

   initial begin
      int w0, r0, b0, a0, n;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_slave = 7'd0; cmd_len = 8'd0;
      busy_n = 0; rdy_n = 0; nack_at = -1; ack_base = 0; lat_mode = 0; glitch_en = 0;
      for (int i = 0; i < 4096; i++) begin
         wpool[i] = 8'($urandom);
         rpool[i] = 8'($urandom);
      end
      repeat (3) @(negedge clk);
      checkOutput("reset_cmd_ready", int'(cmd_ready), 1);
      checkOutput("reset_cyc", int'({o_wb_cyc, o_wb_stb}), 0);
      checkOutput("reset_pulses", int'({wr_pop, rd_valid, done}), 0);
      checkOutput("reset_status", int'(status), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Write 0x50, bytes A5 3C, busy for 3 polls each time
      wpool[pop_cnt % 4096]       = 8'hA5;
      wpool[(pop_cnt + 1) % 4096] = 8'h3C;
      w0 = wlog.size();
      applyStimulus(1'b0, 7'h50, 2, 3, 0, -1, 0, 1'b0);
      checkOutput("t1_nwrites", wlog.size() - w0, 4);
      if (wlog.size() - w0 == 4) begin
         checkOutput("t1_start", int'(wlog[w0]),     int'({1'b1, 8'h00, 8'hA0}));
         checkOutput("t1_byte0", int'(wlog[w0 + 1]), int'({1'b1, 8'h01, 8'hA5}));
         checkOutput("t1_byte1", int'(wlog[w0 + 2]), int'({1'b1, 8'h01, 8'h3C}));
         checkOutput("t1_stop",  int'(wlog[w0 + 3]), int'({1'b1, 8'h02, 8'h01}));
      end
      checkOutput("t1_status", int'(status), 0);

      // Read 0x48, 3 bytes 11 22 33
      rpool[rd_cnt % 4096]       = 8'h11;
      rpool[(rd_cnt + 1) % 4096] = 8'h22;
      rpool[(rd_cnt + 2) % 4096] = 8'h33;
      w0 = wlog.size();
      r0 = rlog.size();
      applyStimulus(1'b1, 7'h48, 3, 1, 2, -1, 0, 1'b0);
      checkOutput("t2_start_data", int'(wlog[w0].data), 8'h91);
      checkOutput("t2_nbytes", rlog.size() - r0, 3);
      if (rlog.size() - r0 == 3) begin
         checkOutput("t2_rd0", int'(rlog[r0]),     8'h11);
         checkOutput("t2_rd1", int'(rlog[r0 + 1]), 8'h22);
         checkOutput("t2_rd2", int'(rlog[r0 + 2]), 8'h33);
      end
      checkOutput("t2_status", int'(status), 0);

      // NACK on the address phase of a 4-byte write
      w0 = wlog.size();
      applyStimulus(1'b0, 7'h3A, 4, 0, 0, 0, 0, 1'b0);
      checkOutput("t3_status", int'(status), 1);
      checkOutput("t3_nwrites", wlog.size() - w0, 2);
      checkOutput("t3_stop", int'(wlog[wlog.size() - 1]), int'({1'b1, 8'h02, 8'h01}));

      // BUSY stuck high: exactly PM polls then STOP
      b0 = busy_total;
      applyStimulus(1'b0, 7'h10, 1, 1000, 0, -1, 0, 1'b0);
      checkOutput("t4_busy_reads", busy_total - b0, 16);
      checkOutput("t4_status", int'(status), 2);
      checkOutput("t4_stop", int'(wlog[wlog.size() - 1]), int'({1'b1, 8'h02, 8'h01}));

      // Address probe with a 1-cycle ack slave
      a0 = acc_total;
      applyStimulus(1'b0, 7'h22, 0, 0, 0, -1, 0, 1'b0);
      checkOutput("t5_accesses", acc_total - a0, 4);
      checkOutput("t5_latency_le12", int'(done_cycle - acc_cycle <= 12), 1);
      checkOutput("t5_status", int'(status), 0);

      // Reset while a slow access is pending
      busy_n = 0; rdy_n = 0; nack_at = -1; lat_mode = 2; ack_base = ack_total;
      modelCommand(1'b0, 7'h33, 1, n);
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_slave = 7'h33; cmd_len = 8'd1;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!o_wb_stb && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t6_stb_seen", int'(o_wb_stb), 1);
      #2 rst_n = 1'b0;
      #1 checkOutput("t6_reset_cyc", int'({o_wb_cyc, o_wb_stb}), 0);
      exp_acc.delete();
      exp_rd.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("t6_cmd_ready", int'(cmd_ready), 1);
      applyStimulus(1'b1, 7'h0F, 2, 1, 1, -1, 0, 1'b0);
      checkOutput("t6_status", int'(status), 0);

      // Randomized commands with variable slave latency and stray acks
      glitch_en = 1;
      for (int k = 0; k < 40; k++) begin
         int len, bn, rn, na;
         len = $urandom_range(0, 5);
         bn  = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
         rn  = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
         na  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
         applyStimulus(1'($urandom), 7'($urandom), len, bn, rn, na, 1, 1'($urandom));
      end

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
